// File: rtl/nn_training_sequencer_if.sv
// nn_training_sequencer_if: control bundle between the solver iteration scheduler and its datapath.
// master: sequencer side (takes START/ERR_*, drives memory strobes, phase, counters).
// slave:  datapath/host side (drives START/ERR_*, observes strobes).
interface nn_training_sequencer_if #(parameter int CNT_W = 16);
  logic START;
  logic ERR_VALID;
  logic ERR_BETTER;
  logic ERR_CONVERGED;
  logic INITIAL_READ_FLAG;
  logic BEST_WR;
  logic STALL;
  logic TRAIN_EN;
  logic OLD_WEIGHT_RD;
  logic WRITE_TRAINING;
  logic UPDATE_WEIGHT;
  logic [1:0] TRAINING_MODE;
  logic FIRST_MANH_DONE;
  logic SECOND_MANH_DONE;
  logic FINISHED;
  logic STOP;
  logic [CNT_W-1:0] ITER_COUNT;
  logic TIMEOUT;
  modport master (
    input START, ERR_VALID, ERR_BETTER, ERR_CONVERGED,
    output INITIAL_READ_FLAG, BEST_WR, STALL, TRAIN_EN, OLD_WEIGHT_RD, WRITE_TRAINING,
    output UPDATE_WEIGHT, TRAINING_MODE, FIRST_MANH_DONE, SECOND_MANH_DONE, FINISHED, STOP,
    output ITER_COUNT, TIMEOUT
  );
  modport slave (
    output START, ERR_VALID, ERR_BETTER, ERR_CONVERGED,
    input INITIAL_READ_FLAG, BEST_WR, STALL, TRAIN_EN, OLD_WEIGHT_RD, WRITE_TRAINING,
    input UPDATE_WEIGHT, TRAINING_MODE, FIRST_MANH_DONE, SECOND_MANH_DONE, FINISHED, STOP,
    input ITER_COUNT, TIMEOUT
  );
endinterface

// File: rtl/nn_training_sequencer.sv
// nn_training_sequencer: iteration scheduler for the NN nonlinear-equation solver (M1 -> M2 -> ADAM -> reload best -> stop).
// Ports: CLK, RESET (sync, active-high), bus (nn_training_sequencer_if.master):
//   in  START, ERR_VALID, ERR_BETTER, ERR_CONVERGED
//   out INITIAL_READ_FLAG, BEST_WR, STALL, TRAIN_EN, OLD_WEIGHT_RD, WRITE_TRAINING, UPDATE_WEIGHT,
//       TRAINING_MODE[1:0], FIRST_MANH_DONE, SECOND_MANH_DONE, FINISHED, STOP, ITER_COUNT[CNT_W-1:0], TIMEOUT
// Optional EVAL watchdog: define NN_SEQ_WATCHDOG_EN (TIMEOUT tied to 0 otherwise).
module nn_training_sequencer #(
  parameter int NUM_UNKNOWNS = 2,
  parameter int PIPE_LAT = 4,
  parameter int EXTRA_CYCLES = 3,
  parameter int ITER_M1 = 16,
  parameter int ITER_M2 = 16,
  parameter int ITER_ADAM = 64,
  parameter int CNT_W = 16,
  parameter int WD_CYCLES = 255
) (
  input logic CLK,
  input logic RESET,
  nn_training_sequencer_if.master bus
);
  localparam logic [3:0] IDLE = 4'd0, LOAD = 4'd1, FILL = 4'd2, TRAIN = 4'd3, EVAL = 4'd4,
                         SAVE = 4'd5, UPDATE = 4'd6, RELOAD = 4'd7, DONE = 4'd8;
  localparam logic [1:0] M1 = 2'b00, M2 = 2'b01, ADAM = 2'b10;
  localparam int FILL_N = PIPE_LAT + EXTRA_CYCLES;
  localparam int MAXV = NUM_UNKNOWNS > FILL_N ? (NUM_UNKNOWNS > WD_CYCLES ? NUM_UNKNOWNS : WD_CYCLES)
                                              : (FILL_N > WD_CYCLES ? FILL_N : WD_CYCLES);
  localparam int CW = $clog2(MAXV + 1) < 1 ? 1 : $clog2(MAXV + 1);
  localparam logic [CNT_W-1:0] L1 = CNT_W'(ITER_M1 < 1 ? 1 : ITER_M1);
  localparam logic [CNT_W-1:0] L2 = CNT_W'(ITER_M2 < 1 ? 1 : ITER_M2);
  localparam logic [CNT_W-1:0] L3 = CNT_W'(ITER_ADAM < 1 ? 1 : ITER_ADAM);
  logic [3:0] state, nxt, dec_nxt;
  logic [CW-1:0] cnt;
  logic [CNT_W-1:0] iter, iter_inc, lim;
  logic [1:0] mode;
  logic conv, dconv, dec, phase_end, last_root, last_fill, start_ok, wd_hit;
  // cnt restarts on every state change: burst index in LOAD/TRAIN/SAVE/RELOAD, fill count, EVAL dwell time
  assign last_root = cnt == CW'(NUM_UNKNOWNS - 1);
  assign last_fill = cnt == CW'(FILL_N - 1);
  assign start_ok = bus.START && (state == IDLE || state == DONE);
  assign lim = mode == M1 ? L1 : mode == M2 ? L2 : L3;
  assign iter_inc = &iter ? iter : iter + 1'b1;
  assign phase_end = iter_inc >= lim;
  // a SAVE defers the decision, so it uses the converged flag captured at ERR_VALID
  assign dconv = state == EVAL ? bus.ERR_CONVERGED : conv;
  assign dec = (state == EVAL && bus.ERR_VALID && !bus.ERR_BETTER) || (state == SAVE && last_root);
  assign dec_nxt = (dconv || (phase_end && mode == ADAM)) ? RELOAD : UPDATE;
`ifdef NN_SEQ_WATCHDOG_EN
  logic timeout;
  assign wd_hit = cnt == CW'(WD_CYCLES);
  always_ff @(posedge CLK)
    if (RESET || start_ok) timeout <= 1'b0;
    else if (state == EVAL && !bus.ERR_VALID && wd_hit) timeout <= 1'b1;
  assign bus.TIMEOUT = timeout;
`else
  assign wd_hit = 1'b0;
  assign bus.TIMEOUT = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = bus.START ? LOAD : state;
      LOAD: nxt = last_root ? FILL : LOAD;
      FILL: nxt = last_fill ? TRAIN : FILL;
      TRAIN: nxt = last_root ? EVAL : TRAIN;
      EVAL: nxt = bus.ERR_VALID ? (bus.ERR_BETTER ? SAVE : dec_nxt) : wd_hit ? RELOAD : EVAL;
      SAVE: nxt = last_root ? dec_nxt : SAVE;
      UPDATE: nxt = FILL;
      RELOAD: nxt = last_root ? DONE : RELOAD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      iter <= '0;
      mode <= M1;
      conv <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      if (state == EVAL && bus.ERR_VALID) conv <= bus.ERR_CONVERGED;
      if (dec && !dconv) begin
        iter <= phase_end ? '0 : iter_inc;
        if (phase_end && mode != ADAM) mode <= mode + 2'd1;
      end
      if (start_ok) begin
        iter <= '0;
        mode <= M1;
      end
    end
  assign bus.INITIAL_READ_FLAG = state == LOAD;
  assign bus.BEST_WR = state == LOAD || state == SAVE;
  assign bus.STALL = state == FILL;
  assign bus.TRAIN_EN = state == TRAIN;
  assign bus.OLD_WEIGHT_RD = state == TRAIN;
  assign bus.WRITE_TRAINING = state == TRAIN;
  assign bus.UPDATE_WEIGHT = state == UPDATE;
  // iter is 0 inside UPDATE only right after a phase advance, so these decode to the first-UPDATE pulse
  assign bus.FIRST_MANH_DONE = state == UPDATE && mode == M2 && iter == '0;
  assign bus.SECOND_MANH_DONE = state == UPDATE && mode == ADAM && iter == '0;
  assign bus.FINISHED = state == RELOAD;
  assign bus.STOP = state == DONE;
  assign bus.TRAINING_MODE = mode;
  assign bus.ITER_COUNT = iter;
endmodule

// File: tb/tb_nn_training_sequencer.sv
// tb_nn_training_sequencer: directed self-checking bench for nn_training_sequencer.
module tb_nn_training_sequencer;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int tests = 0;
  int fails = 0;
  nn_training_sequencer_if #(.CNT_W(16)) bus ();
  nn_training_sequencer #(
    .NUM_UNKNOWNS(2), .PIPE_LAT(4), .EXTRA_CYCLES(3),
    .ITER_M1(2), .ITER_M2(2), .ITER_ADAM(3), .CNT_W(16), .WD_CYCLES(10)
  ) dut (.CLK(CLK), .RESET(RESET), .bus(bus.master));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  function automatic logic [10:0] strobes();
    return {bus.INITIAL_READ_FLAG, bus.BEST_WR, bus.STALL, bus.TRAIN_EN, bus.OLD_WEIGHT_RD,
            bus.WRITE_TRAINING, bus.UPDATE_WEIGHT, bus.FIRST_MANH_DONE, bus.SECOND_MANH_DONE,
            bus.FINISHED, bus.STOP};
  endfunction
  task automatic check_reset(input string tag);
    check({tag, "_strobes"}, 32'(strobes()), 32'd0);
    check({tag, "_mode"}, 32'(bus.TRAINING_MODE), 32'd0);
    check({tag, "_iter"}, 32'(bus.ITER_COUNT), 32'd0);
    check({tag, "_timeout"}, 32'(bus.TIMEOUT), 32'd0);
  endtask
  task automatic start_solve();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
  endtask
  task automatic eval_result(input logic better, input logic conv);
    bus.ERR_VALID = 1'b1;
    bus.ERR_BETTER = better;
    bus.ERR_CONVERGED = conv;
    step();
    bus.ERR_VALID = 1'b0;
    bus.ERR_BETTER = 1'b0;
    bus.ERR_CONVERGED = 1'b0;
  endtask
  task automatic update_to_eval();
    step();
    check("refill_stall", 32'(bus.STALL), 32'd1);
    repeat (7) step();
    check("retrain_en", 32'(bus.TRAIN_EN), 32'd1);
    repeat (2) step();
    check("reeval_quiet", 32'(strobes()), 32'd0);
  endtask
  int exp_iter[7] = '{1, 0, 1, 0, 1, 2, 0};
  int exp_mode[7] = '{0, 1, 1, 2, 2, 2, 2};
  initial begin
    bus.START = 1'b0;
    bus.ERR_VALID = 1'b0;
    bus.ERR_BETTER = 1'b0;
    bus.ERR_CONVERGED = 1'b0;
    step();
    step();
    check_reset("reset");
    RESET = 1'b0;
    // ERR_VALID in IDLE must be ignored
    bus.ERR_VALID = 1'b1;
    step();
    bus.ERR_VALID = 1'b0;
    check_reset("idle_errvalid");
    // 1: first-iteration timeline
    start_solve();
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("t1_irf_c%0d", c), 32'(bus.INITIAL_READ_FLAG), 32'(c <= 2));
      check($sformatf("t1_stall_c%0d", c), 32'(bus.STALL), 32'(c >= 3 && c <= 9));
      check($sformatf("t1_train_c%0d", c), 32'(bus.TRAIN_EN), 32'(c >= 10 && c <= 11));
      check($sformatf("t1_wrtr_c%0d", c), 32'(bus.WRITE_TRAINING), 32'(c >= 10 && c <= 11));
      if (c < 12) step();
    end
    check("t1_eval_quiet", 32'(strobes()), 32'd0);
    // 2: run all three phases to exhaustion
    for (int i = 0; i < 7; i++) begin
      eval_result(1'b0, 1'b0);
      check($sformatf("t2_mode_i%0d", i + 1), 32'(bus.TRAINING_MODE), 32'(exp_mode[i]));
      check($sformatf("t2_iter_i%0d", i + 1), 32'(bus.ITER_COUNT), 32'(exp_iter[i]));
      if (i < 6) begin
        check($sformatf("t2_upd_i%0d", i + 1), 32'(bus.UPDATE_WEIGHT), 32'd1);
        check($sformatf("t2_m1done_i%0d", i + 1), 32'(bus.FIRST_MANH_DONE), 32'(i == 1));
        check($sformatf("t2_m2done_i%0d", i + 1), 32'(bus.SECOND_MANH_DONE), 32'(i == 3));
        update_to_eval();
      end
    end
    check("t2_fin1", 32'(bus.FINISHED), 32'd1);
    check("t2_noupd", 32'(bus.UPDATE_WEIGHT), 32'd0);
    step();
    check("t2_fin2", 32'(bus.FINISHED), 32'd1);
    step();
    check("t2_fin_off", 32'(bus.FINISHED), 32'd0);
    check("t2_stop", 32'(bus.STOP), 32'd1);
    step();
    check("t2_stop_hold", 32'(bus.STOP), 32'd1);
    // 3: better error in iteration 1 -> two-cycle SAVE burst
    start_solve();
    check("t3_stop_clr", 32'(bus.STOP), 32'd0);
    check("t3_load", 32'(bus.INITIAL_READ_FLAG), 32'd1);
    check("t3_mode_clr", 32'(bus.TRAINING_MODE), 32'd0);
    repeat (11) step();
    eval_result(1'b1, 1'b0);
    bus.ERR_VALID = 1'b1;
    check("t3_save1", 32'(bus.BEST_WR), 32'd1);
    check("t3_save1_noirf", 32'(bus.INITIAL_READ_FLAG), 32'd0);
    step();
    check("t3_save2", 32'(bus.BEST_WR), 32'd1);
    step();
    bus.ERR_VALID = 1'b0;
    check("t3_save_off", 32'(bus.BEST_WR), 32'd0);
    check("t3_upd", 32'(bus.UPDATE_WEIGHT), 32'd1);
    check("t3_iter", 32'(bus.ITER_COUNT), 32'd1);
    update_to_eval();
    // 4: converge in iteration 3
    eval_result(1'b0, 1'b0);
    check("t4_m1done", 32'(bus.FIRST_MANH_DONE), 32'd1);
    update_to_eval();
    eval_result(1'b0, 1'b1);
    check("t4_noupd", 32'(bus.UPDATE_WEIGHT), 32'd0);
    check("t4_fin", 32'(bus.FINISHED), 32'd1);
    check("t4_mode", 32'(bus.TRAINING_MODE), 32'd1);
    check("t4_iter", 32'(bus.ITER_COUNT), 32'd0);
    repeat (2) step();
    check("t4_stop", 32'(bus.STOP), 32'd1);
    check("t4_mode_hold", 32'(bus.TRAINING_MODE), 32'd1);
    // 5: START in FILL ignored, RESET mid-TRAIN
    start_solve();
    check("t5_mode_clr", 32'(bus.TRAINING_MODE), 32'd0);
    step();
    step();
    check("t5_fill", 32'(bus.STALL), 32'd1);
    start_solve();
    check("t5_fill_start", 32'(bus.STALL), 32'd1);
    check("t5_fill_noload", 32'(bus.INITIAL_READ_FLAG), 32'd0);
    repeat (5) step();
    check("t5_fill_last", 32'(bus.STALL), 32'd1);
    step();
    check("t5_train", 32'(bus.TRAIN_EN), 32'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check_reset("t5_reset");
    step();
    check_reset("t5_idle");
    // 6: EVAL with ERR_VALID withheld
    start_solve();
    repeat (11) step();
`ifdef NN_SEQ_WATCHDOG_EN
    repeat (10) step();
    check("t6_pre_fin", 32'(bus.FINISHED), 32'd0);
    check("t6_pre_to", 32'(bus.TIMEOUT), 32'd0);
    step();
    check("t6_fin", 32'(bus.FINISHED), 32'd1);
    check("t6_to", 32'(bus.TIMEOUT), 32'd1);
    repeat (2) step();
    check("t6_stop", 32'(bus.STOP), 32'd1);
    check("t6_to_hold", 32'(bus.TIMEOUT), 32'd1);
    start_solve();
    check("t6_to_clr", 32'(bus.TIMEOUT), 32'd0);
`else
    repeat (300) step();
    check("t6_wait_quiet", 32'(strobes()), 32'd0);
    check("t6_no_timeout", 32'(bus.TIMEOUT), 32'd0);
    eval_result(1'b0, 1'b1);
    check("t6_late_fin", 32'(bus.FINISHED), 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nn_training_sequencer.md
Name: nn_training_sequencer

Overview:
- Iteration scheduler for the NN nonlinear-equation solver.
- Sequences each training iteration: initial-guess load, pipeline fill, root update, error evaluation and best-root capture.
- Walks the optimiser phases Manhattan-1, then Manhattan-2, then Adam, then reloads the best roots and raises stop.
- Drives the read/write strobes of the ROM, the best-weights memory and the old-weights memory, and the training-block enables.

Parameters:
- NUM_UNKNOWNS, 2, roots per system; the length of every per-root strobe burst.
- PIPE_LAT, 4, forward plus backward engine latency in cycles.
- EXTRA_CYCLES, 3, extra wasted cycles added to each fill.
- ITER_M1, 16, iterations in Manhattan phase 1.
- ITER_M2, 16, iterations in Manhattan phase 2.
- ITER_ADAM, 64, iterations in Adam phase.
- CNT_W, 16, width of the iteration counter.
- WD_CYCLES, 255, EVAL watchdog limit (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset: synchronous, active-high; clock is CLK.
- START  in  1  begin a solve; sampled only in IDLE and DONE.
- ERR_VALID  in  1  iteration error is ready.
- ERR_BETTER  in  1  new error is below best error; qualified by ERR_VALID.
- ERR_CONVERGED  in  1  error is below tolerance; qualified by ERR_VALID.
- INITIAL_READ_FLAG  out  1  load ROM initial guess.
- BEST_WR  out  1  write to best-weights memory.
- STALL  out  1  pipeline fill; training block held.
- TRAIN_EN  out  1  training block active.
- OLD_WEIGHT_RD  out  1  read old-weights memory.
- WRITE_TRAINING  out  1  write updated roots.
- UPDATE_WEIGHT  out  1  one-cycle commit of the updated roots.
- TRAINING_MODE  out  2  optimiser phase: 00 = M1, 01 = M2, 10 = ADAM.
- FIRST_MANH_DONE  out  1  one-cycle pulse at the M1 to M2 transition.
- SECOND_MANH_DONE  out  1  one-cycle pulse at the M2 to ADAM transition.
- FINISHED  out  1  read best-weights memory for the final reload.
- STOP  out  1  solve complete.
- ITER_COUNT  out  CNT_W  iterations completed in the current phase.
- TIMEOUT  out  1  watchdog fired (optional feature only).

Behaviour:
- Moore FSM; every output is decoded from registered state and counters.
- Reset: state IDLE; all outputs 0; TRAINING_MODE = 00; ITER_COUNT = 0.
- RESET asserted at any point, including mid-burst, returns to these values at the next edge.
- States: IDLE, LOAD, FILL, TRAIN, EVAL, SAVE, UPDATE, RELOAD, DONE.
- IDLE: when START = 1, go to LOAD.
- LOAD: INITIAL_READ_FLAG = 1 and BEST_WR = 1 for NUM_UNKNOWNS cycles, indexed by a root counter. Then FILL.
- FILL: STALL = 1 for PIPE_LAT + EXTRA_CYCLES cycles. Then TRAIN.
- TRAIN: TRAIN_EN, OLD_WEIGHT_RD and WRITE_TRAINING all 1 for NUM_UNKNOWNS cycles. Then EVAL.
- EVAL: all strobes 0; waits indefinitely for ERR_VALID, which is sampled from the first EVAL cycle.
  - ERR_VALID outside EVAL is ignored.
  - On ERR_VALID: if ERR_BETTER, go to SAVE; otherwise go to the decision step.
- SAVE: BEST_WR = 1 for NUM_UNKNOWNS cycles, then the decision step.
  - The ERR_CONVERGED value captured at ERR_VALID is held internally for the decision.
- Decision step (combinational, at exit of EVAL or SAVE):
  - If converged, go to RELOAD.
  - Otherwise increment ITER_COUNT.
  - If ITER_COUNT reaches the limit for the current phase: clear ITER_COUNT, advance TRAINING_MODE and pulse the matching *_DONE in the first UPDATE cycle.
  - If the phase was ADAM, go to RELOAD instead.
  - Otherwise go to UPDATE.
- UPDATE: UPDATE_WEIGHT = 1 for one cycle, then FILL.
- RELOAD: FINISHED = 1 for NUM_UNKNOWNS cycles, then DONE.
- DONE: STOP = 1 and holds. START = 1 clears STOP, resets TRAINING_MODE and ITER_COUNT, and goes to LOAD.
- START is ignored in every state other than IDLE and DONE.
- Counter rules: ITER_COUNT saturates at 2^CNT_W - 1. A phase limit of 0 is treated as 1.

Optional Feature:
- Macro NN_SEQ_WATCHDOG_EN.
- Defined: a counter runs while in EVAL. If ERR_VALID is not seen within WD_CYCLES cycles, go to RELOAD and set TIMEOUT = 1, held until RESET or START.
- Undefined: no watchdog; EVAL waits forever; TIMEOUT is tied to 0.

Test Plan:
Common parameters: NUM_UNKNOWNS = 2, PIPE_LAT = 4, EXTRA_CYCLES = 3, ITER_M1 = 2, ITER_M2 = 2, ITER_ADAM = 3.
1. Reset then START at edge 0 -> INITIAL_READ_FLAG high in cycles 1–2, STALL high in cycles 3–9, TRAIN_EN / WRITE_TRAINING high in cycles 10–11, EVAL from cycle 12.
2. ERR_VALID every EVAL with ERR_BETTER = 0 and ERR_CONVERGED = 0 -> FIRST_MANH_DONE after iteration 2 and SECOND_MANH_DONE after iteration 4; TRAINING_MODE steps 00, 01, 10; after 7 iterations FINISHED is high for 2 cycles, then STOP = 1.
3. ERR_VALID with ERR_BETTER = 1 in iteration 1 -> BEST_WR high for exactly 2 cycles before UPDATE; ITER_COUNT = 1.
4. ERR_CONVERGED = 1 in iteration 3 -> no UPDATE_WEIGHT; RELOAD then STOP; TRAINING_MODE = 01.
5. RESET asserted mid-TRAIN, and START pulsed during FILL -> reset returns all outputs to reset values next edge; START during FILL causes no state change.
6. With NN_SEQ_WATCHDOG_EN and WD_CYCLES = 10, ERR_VALID withheld -> TIMEOUT = 1 and FINISHED asserted 11 cycles after EVAL entry, then STOP = 1.
